// File: rtl/bnw_pkg.sv
// Block heights, hit-window bounds and judgement codes shared by the block
// stages, the hit judge and the display.
package bnw_pkg;

  localparam int H_SPAWN  = 120;
  localparam int H_OFF    = 720;
  localparam int WIN_TOP  = 600;
  localparam int WIN_BOT  = 680;
  localparam int PERF_TOP = 630;
  localparam int PERF_BOT = 660;

  localparam logic [1:0] JUDGE_NONE    = 2'd0;
  localparam logic [1:0] JUDGE_MISS    = 2'd1;
  localparam logic [1:0] JUDGE_GOOD    = 2'd2;
  localparam logic [1:0] JUDGE_PERFECT = 2'd3;

  function automatic logic h_in(input logic [9:0] h, input int lo, input int hi);
    return (int'(h) >= lo) && (int'(h) <= hi);
  endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Lane heights and keys into the judge, score/combo/judgement out of it.
interface hit_judge_if #(parameter int LANES = 4);

  logic                   restart;
  logic                   stop_or_endgame;
  logic [10*LANES-1:0]    block_h;
  logic [LANES-1:0]       key;
  logic [13:0]            score;
  logic [7:0]             combo;
  logic [7:0]             max_combo;
  logic [1:0]             judge;
  logic [1:0]             judge_lane;

  modport master (
    output restart, stop_or_endgame, block_h, key,
    input  score, combo, max_combo, judge, judge_lane
  );

  modport slave (
    input  restart, stop_or_endgame, block_h, key,
    output score, combo, max_combo, judge, judge_lane
  );

endinterface

// File: rtl/hit_judge_lane_judge.sv
// One lane: key edge detect and WAIT/WIN/DONE tracking of the falling block.
// Emits registered 1-cycle hit_perf/hit_good/miss pulses, one per block.
module lane_judge
  import bnw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       stop,
  input  logic [9:0] h,
  input  logic       key,
  output logic       hit_perf,
  output logic       hit_good,
  output logic       miss
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_WIN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state;
  logic       key_q;
  logic       press;
  logic       in_win;
  logic       in_perf;
  logic       below;
  logic       above;

  assign press   = key & ~key_q;
  assign in_win  = h_in(h, WIN_TOP, WIN_BOT);
  assign in_perf = h_in(h, PERF_TOP, PERF_BOT);
  assign below   = int'(h) < WIN_TOP;
  assign above   = int'(h) > WIN_BOT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_DONE;
      key_q    <= 1'b0;
      hit_perf <= 1'b0;
      hit_good <= 1'b0;
      miss     <= 1'b0;
    end else if (restart) begin
      state    <= ST_DONE;
      key_q    <= 1'b0;
      hit_perf <= 1'b0;
      hit_good <= 1'b0;
      miss     <= 1'b0;
    end else begin
      // key_q keeps tracking during a pause so a held key cannot fire on resume
      key_q    <= key;
      hit_perf <= 1'b0;
      hit_good <= 1'b0;
      miss     <= 1'b0;
      if (!stop) begin
        case (state)
          ST_WAIT: if (in_win) state <= ST_WIN;
          ST_WIN: begin
            // leaving the window wins over a same-cycle press
            if (below || above) begin
              miss  <= 1'b1;
              state <= below ? ST_WAIT : ST_DONE;
            end else if (press) begin
              hit_perf <= in_perf;
              hit_good <= ~in_perf;
              state    <= ST_DONE;
            end
          end
          ST_DONE: if (below) state <= ST_WAIT;
          default: state <= ST_DONE;
        endcase
      end
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Per-lane judging plus score/combo accounting and a held judgement display.
// Key press at edge N shows on the outputs at edge N+1; stop freezes everything but key tracking.
module hit_judge
  import bnw_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int SHOW_TICKS = 5,
  parameter int SCORE_MAX  = 9999
) (
  input logic        clk,
  input logic        rst_n,
  hit_judge_if.slave bus
);

  localparam int TW = $clog2(SHOW_TICKS + 1);

  logic [LANES-1:0] hit_perf;
  logic [LANES-1:0] hit_good;
  logic [LANES-1:0] miss;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_judge u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .restart  (bus.restart),
      .stop     (bus.stop_or_endgame),
      .h        (bus.block_h[10*i +: 10]),
      .key      (bus.key[i]),
      .hit_perf (hit_perf[i]),
      .hit_good (hit_good[i]),
      .miss     (miss[i])
    );
  end

  logic [13:0]   score_q;
  logic [7:0]    combo_q;
  logic [7:0]    max_q;
  logic [1:0]    judge_q;
  logic [1:0]    lane_q;
  logic [TW-1:0] timer_q;

  logic [7:0]  add;
  logic [7:0]  n_hit;
  logic        any_miss;
  logic        any_evt;
  logic [1:0]  evt_code;
  logic [1:0]  evt_lane;
  logic [14:0] score_sum;
  logic [8:0]  combo_sum;
  logic [13:0] score_next;
  logic [7:0]  combo_next;
  logic [7:0]  max_next;

  // Walk from the top lane down so the lowest-index event is reported.
  always_comb begin
    add      = '0;
    n_hit    = '0;
    any_miss = 1'b0;
    any_evt  = 1'b0;
    evt_code = JUDGE_NONE;
    evt_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hit_perf[i]) begin
        add   = add + 8'd3;
        n_hit = n_hit + 8'd1;
      end else if (hit_good[i]) begin
        add   = add + 8'd1;
        n_hit = n_hit + 8'd1;
      end
      if (miss[i]) any_miss = 1'b1;
      if (hit_perf[i] || hit_good[i] || miss[i]) begin
        any_evt  = 1'b1;
        evt_lane = 2'(i);
        evt_code = hit_perf[i] ? JUDGE_PERFECT : (hit_good[i] ? JUDGE_GOOD : JUDGE_MISS);
      end
    end
  end

  assign score_sum  = {1'b0, score_q} + 15'(add);
  assign score_next = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
  assign combo_sum  = {1'b0, combo_q} + 9'(n_hit);
  assign combo_next = any_miss ? 8'd0 : ((combo_sum > 9'd255) ? 8'd255 : combo_sum[7:0]);
  assign max_next   = (combo_next > max_q) ? combo_next : max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
      judge_q <= JUDGE_NONE;
      lane_q  <= '0;
      timer_q <= '0;
    end else if (bus.restart) begin
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
      judge_q <= JUDGE_NONE;
      lane_q  <= '0;
      timer_q <= '0;
    end else if (any_evt) begin
      score_q <= score_next;
      combo_q <= combo_next;
      max_q   <= max_next;
      judge_q <= evt_code;
      lane_q  <= evt_lane;
      timer_q <= TW'(SHOW_TICKS);
    end else if (!bus.stop_or_endgame && timer_q != '0) begin
      timer_q <= timer_q - 1'b1;
      if (timer_q == TW'(1)) judge_q <= JUDGE_NONE;
    end
  end

  assign bus.score      = score_q;
  assign bus.combo      = combo_q;
  assign bus.max_combo  = max_q;
  assign bus.judge      = judge_q;
  assign bus.judge_lane = lane_q;

endmodule
